// File: rtl/fb_arb_pkg.sv
// Shared widths, read latency and the buffered-write payload for the framebuffer arbiter.
package fb_arb_pkg;

    localparam int unsigned FB_ADDR_W = 18;
    localparam int unsigned FB_DATA_W = 8;
    localparam int unsigned RD_LAT    = 2;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_wr_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Circular write buffer with registered full flag, level count and a youngest-match
// address lookup across all valid entries.
module fb_wr_fifo
    import fb_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  fb_wr_t               push_entry,
    input  logic                 pop,
    output fb_wr_t               head_c,
    output logic                 full,
    output logic                 empty_c,
    output logic [LVL_W-1:0]     level,
    input  logic [FB_ADDR_W-1:0] match_addr,
    output logic                 match_hit_c,
    output logic [FB_DATA_W-1:0] match_data_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fb_wr_t             entries_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               full_q, full_d;
    logic               push_ok, pop_ok;
    logic [PTR_W-1:0]   idx;

    assign empty_c = (level_q == '0);
    assign full    = full_q;
    assign level   = level_q;
    assign head_c  = entries_q[rd_ptr_q];
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_c;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d = (level_d == LVL_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
        end
    end

    // Payload storage needs no reset: only entries below level are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok) entries_q[wr_ptr_q] <= push_entry;
    end

    // Walk oldest to youngest so the last hit found is the youngest write.
    always_comb begin
        match_hit_c  = 1'b0;
        match_data_c = '0;
        idx          = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((LVL_W'(i) < level_q) && (entries_q[idx].addr == match_addr)) begin
                match_hit_c  = 1'b1;
                match_data_c = entries_q[idx].data;
            end
        end
    end

endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer sharing: scan-out reads take every cycle they ask for, processor
// writes are buffered and committed in idle cycles, reads bypass from the buffer on a hit.
module framebuffer_arbiter
    import fb_arb_pkg::*;
#(
    parameter  int unsigned ADDR_W       = FB_ADDR_W,
    parameter  int unsigned DATA_W       = FB_DATA_W,
    parameter  int unsigned FIFO_DEPTH   = 4,
    parameter  int unsigned STARVE_LIMIT = 1024,
    localparam int unsigned LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_rd_en,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              starved
);

    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

    fb_wr_t               push_entry, head;
    logic                 full, empty_c, commit_c, push_c;
    logic                 hit_c;
    logic [FB_DATA_W-1:0] hit_data_c;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_hit_q, s1_hit_d;
    logic [DATA_W-1:0]    s1_data_q, s1_data_d;
    logic                 disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0]    disp_data_q, disp_data_d;
    logic [SC_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                 starved_q, starved_d;

    assign commit_c     = !disp_rd_en && !empty_c;
    assign push_c       = cpu_wr_valid && !full;
    assign cpu_wr_ready = !full;
    assign push_entry   = '{addr: FB_ADDR_W'(cpu_wr_addr), data: FB_DATA_W'(cpu_wr_data)};

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push_c),
        .push_entry   (push_entry),
        .pop          (commit_c),
        .head_c       (head),
        .full         (full),
        .empty_c      (empty_c),
        .level        (fifo_level),
        .match_addr   (FB_ADDR_W'(disp_addr)),
        .match_hit_c  (hit_c),
        .match_data_c (hit_data_c)
    );

    // Port grant: reads win outright, otherwise drain the buffer head.
    assign mem_we    = commit_c;
    assign mem_addr  = commit_c ? ADDR_W'(head.addr) : disp_addr;
    assign mem_wdata = DATA_W'(head.data);

    always_comb begin
        s1_valid_d   = disp_rd_en;
        s1_hit_d     = disp_rd_en && hit_c;
        s1_data_d    = DATA_W'(hit_data_c);
        disp_valid_d = s1_valid_q;
        disp_data_d  = disp_data_q;
        if (s1_valid_q) disp_data_d = s1_hit_q ? s1_data_q : mem_q;

        starve_cnt_d = starve_cnt_q;
        starved_d    = starved_q;
        if (commit_c)
            starve_cnt_d = '0;
        else if (full && disp_rd_en && (starve_cnt_q != SC_W'(STARVE_LIMIT)))
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        if (starve_cnt_d == SC_W'(STARVE_LIMIT)) starved_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_hit_q     <= 1'b0;
            s1_data_q    <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            starve_cnt_q <= '0;
            starved_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_hit_q     <= s1_hit_d;
            s1_data_q    <= s1_data_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            starve_cnt_q <= starve_cnt_d;
            starved_q    <= starved_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign starved    = starved_q;

endmodule
